// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the VGA sync generator and its consumer (renderer / pins).
interface vga_sync_gen_if;
    localparam int unsigned CW = 10;

    logic          en;
    logic          pix_en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;

    // Consumer side: gates the raster and samples the timing outputs.
    modport master (
        output en,
        input  pix_en, hsync, vsync, video_on, pix_x, pix_y, line_start, frame_start
    );

    // Generator side.
    modport slave (
        input  en,
        output pix_en, hsync, vsync, video_on, pix_x, pix_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator on the 50 MHz clock with an internal 25 MHz pixel enable.
// All outputs are registered decodes of the pixel counters, held two cycles per pixel.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    vga_sync_gen_if.slave  vga
);
    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          phase_q, phase_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q       <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Counters advance on the second half of each pixel; decodes lag them by one cycle,
    // so the strobe lands in the second cycle a coordinate is shown.
    always_comb begin
        phase_d       = phase_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_en_d      = phase_q & vga.en;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        if (vga.en) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CW'(1);
                end
            end

            video_on_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
            pix_x_d       = h_cnt_q;
            pix_y_d       = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: expected pixel samples are queued by the stimulus
// and popped by a monitor on every PIX_EN sample; timing intervals are measured alongside.
module tb_vga_sync_gen;
    // Shortened vertical timing keeps a full frame at 13 lines (20800 cycles).
    localparam int unsigned V_TOTAL = 13;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       line_start;
        logic       frame_start;
    } sample_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    vga_sync_gen_if vif();

    vga_sync_gen #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .vga    (vif)
    );

    sample_t exp_q[$];
    int      checks  = 0;
    int      passes  = 0;
    int      cyc     = 0;
    int      nx      = 0;
    int      ny      = 0;
    bit      measure = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Expected sample for a coordinate: 640x6 active, hsync low x in [656,752), vsync low y in [8,10).
    function automatic sample_t expect_at(input int x, input int y);
        sample_t s;
        s.x           = 10'(x);
        s.y           = 10'(y);
        s.video_on    = (x < 640) && (y < 6);
        s.hsync       = !((x >= 656) && (x < 752));
        s.vsync       = !((y >= 8) && (y < 10));
        s.line_start  = (x == 0);
        s.frame_start = (x == 0) && (y == 0);
        return s;
    endfunction

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(expect_at(nx, ny));
            nx++;
            if (nx == 800) begin
                nx = 0;
                ny = (ny == V_TOTAL - 1) ? 0 : ny + 1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_en"},      int'(vif.pix_en),      0);
        check({tag, "_hsync"},       int'(vif.hsync),       1);
        check({tag, "_vsync"},       int'(vif.vsync),       1);
        check({tag, "_video_on"},    int'(vif.video_on),    0);
        check({tag, "_pix_x"},       int'(vif.pix_x),       0);
        check({tag, "_pix_y"},       int'(vif.pix_y),       0);
        check({tag, "_line_start"},  int'(vif.line_start),  0);
        check({tag, "_frame_start"}, int'(vif.frame_start), 0);
    endtask

    // Scoreboard monitor: every strobed sample must match the head of the queue.
    always @(negedge clk) begin
        if (vif.pix_en) begin
            sample_t a, e;
            a = '{vif.pix_x, vif.pix_y, vif.video_on, vif.hsync, vif.vsync,
                  vif.line_start, vif.frame_start};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_sample: got (%0d,%0d), expected no strobe", a.x, a.y);
            end else begin
                e = exp_q.pop_front();
                if (a == e) passes++;
                else $display("FAIL sample: got (%0d,%0d) von=%b hs=%b vs=%b ls=%b fs=%b, expected (%0d,%0d) von=%b hs=%b vs=%b ls=%b fs=%b",
                              a.x, a.y, a.video_on, a.hsync, a.vsync, a.line_start, a.frame_start,
                              e.x, e.y, e.video_on, e.hsync, e.vsync, e.line_start, e.frame_start);
            end
        end
    end

    // Interval measurements in CLK50 cycles while the raster runs uninterrupted.
    int last_ls = -1, last_fs = -1, hs_run = 0, vs_run = 0;
    int frame_act = 0, line_act = 0, line_y = 0;
    always @(negedge clk) begin
        if (measure) begin
            if (vif.pix_en && vif.line_start) begin
                if (last_ls >= 0) begin
                    check("line_period", cyc - last_ls, 1600);
                    check("line_active", line_act, (line_y < 6) ? 640 : 0);
                end
                last_ls  = cyc;
                line_act = 0;
                line_y   = int'(vif.pix_y);
            end
            if (vif.pix_en && vif.frame_start) begin
                if (last_fs >= 0) begin
                    check("frame_period", cyc - last_fs, 20800);
                    check("frame_active", frame_act, 3840);
                end
                last_fs   = cyc;
                frame_act = 0;
            end
            if (vif.pix_en && vif.video_on) begin
                line_act++;
                frame_act++;
            end
            if (!vif.hsync) hs_run++;
            else if (hs_run != 0) begin
                check("hsync_low_cycles", hs_run, 192);
                hs_run = 0;
            end
            if (!vif.vsync) vs_run++;
            else if (vs_run != 0) begin
                check("vsync_low_cycles", vs_run, 3200);
                vs_run = 0;
            end
        end
    end

    initial begin
        vif.en = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // One full frame, the wrap, and on to (100,2) of the next frame.
        push_pixels(12101);
        #1;
        measure = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("pix_en_cycle1", int'(vif.pix_en), 0);
        @(negedge clk);
        check("pix_en_cycle2", int'(vif.pix_en), 1);
        wait_drain(30000);

        // Freeze for 37 cycles right after the (100,2) sample.
        measure = 1'b0;
        vif.en  = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            check("freeze_pix_en", int'(vif.pix_en), 0);
            check("freeze_pix_x",  int'(vif.pix_x),  100);
            check("freeze_pix_y",  int'(vif.pix_y),  2);
            check("freeze_video",  int'(vif.video_on), 1);
        end
        #1;
        push_pixels(2700);
        vif.en = 1'b1;
        wait_drain(6000);

        // Asynchronous reset right after the (400,5) sample, away from any clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        #1;
        nx = 0;
        ny = 0;
        push_pixels(801);
        rst_n = 1'b1;
        wait_drain(2000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
